wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_pkg.sv | 30 +++
 rtl/wb_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_pkg.sv
// ---------------------------------------------------------------------------
// wb_cmd_pkg
// Shared definitions for the Wishbone command master:
//   - state_e          : FSM state encoding (IDLE / BUS / RESP)
//   - TIMEOUT_DEFAULT  : default ack wait limit in cycles
//   - TIMER_W          : width of the ack wait timer
//   - ERR_DATA         : response data returned on a timed-out transfer
//   - timer_expired()  : true on the last cycle the master may wait for ack
// ---------------------------------------------------------------------------
package wb_cmd_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned TIMER_W         = 16;
    localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The timer counts completed stb cycles without ack, starting at 0 on
    // the first stb cycle. The cycle where it equals limit-1 is therefore
    // the limit-th stb cycle, which is the last one the slave may ack.
    function automatic logic timer_expired(input logic [TIMER_W-1:0] timer,
                                           input logic [TIMER_W-1:0] last);
        return (timer == last);
    endfunction

endpackage : wb_cmd_pkg

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
// Converts single commands from a valid/ready stream into Wishbone classic
// single-beat transfers and returns one response per command. If the slave
// does not ack within TIMEOUT stb cycles the transfer is abandoned and an
// error response carrying ERR_DATA is returned instead.
//
// Parameters
//   TIMEOUT      : max stb cycles to wait for ack (1..65535)
// Ports
//   wb_clk_i     : clock, all state on rising edge
//   wb_rst_ni    : asynchronous active-low reset (deassertion synchronised
//                  outside this block)
//   cmd_valid_i / cmd_ready_o          : command handshake
//   cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i : command fields
//   rsp_valid_o / rsp_ready_i          : response handshake
//   rsp_dat_o, rsp_err_o               : read data (0 for writes), timeout flag
//   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o :
//                  registered Wishbone master request
//   wbm_ack_i, wbm_dat_i               : slave acknowledge and read data
//   busy_o       : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,

    output logic        busy_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUS  = ST_BUS;
    localparam logic [1:0] S_RESP = ST_RESP;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    // FSM and ack wait timer
    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;

    // Registered request fields, driven straight onto the bus
    logic               r_cyc;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;

    // Registered response fields
    logic [31:0]        r_rsp_dat;
    logic               r_rsp_err;

    // Decoded handshakes
    logic               w_idle;
    logic               w_accept;
    logic               w_bus_ack;
    logic               w_bus_expire;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle && cmd_valid_i;
    // Ack is only meaningful while the request is on the bus; a stray ack
    // in IDLE or RESP is ignored by construction.
    assign w_bus_ack    = (r_state == S_BUS) && wbm_ack_i;
    // Ack has priority: expiry only counts in a cycle without ack.
    assign w_bus_expire = (r_state == S_BUS) && !wbm_ack_i
                          && timer_expired(r_timer, TIMER_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= cmd_we_i;
                        r_sel   <= cmd_sel_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_timer <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (w_bus_ack) begin
                        r_cyc     <= 1'b0;
                        r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
                        r_rsp_err <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_bus_expire) begin
                        r_cyc     <= 1'b0;
                        r_rsp_dat <= ERR_DATA;
                        r_rsp_err <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Single-beat classic cycles: cyc and stb always move together.
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

    assign cmd_ready_o = w_idle;
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = !w_idle;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
// Self-checking bench for wb_cmd_master (TIMEOUT = 8). A behavioural slave
// acks after a programmable number of stb cycles; stray acks with random
// data are injected while the master is off the bus. Expected responses
// come from a fixed vector table, hand sequences, and a small rule-based
// model for randomized transactions.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic        busy;

    wb_cmd_master #(.TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_dat_i),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          ack_delay  = NEVER;   // ack in stb cycle index ack_delay (0-based)
    int          stb_cnt    = 0;
    logic [31:0] slave_data = '0;
    logic        stray_en   = 1'b0;
    logic        stray_ack  = 1'b0;
    logic [31:0] stray_data = '0;

    always @(posedge clk) begin
        if (wbm_cyc && wbm_stb) stb_cnt <= stb_cnt + 1;
        else                    stb_cnt <= 0;
    end

    always @(negedge clk) begin
        stray_ack  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        stray_data = $urandom;
    end

    assign wbm_ack   = (wbm_cyc && wbm_stb && (stb_cnt == ack_delay)) || (stray_ack && !wbm_cyc);
    assign wbm_dat_i = wbm_cyc ? slave_data : stray_data;

    // ---------------- bus monitor ----------------
    int          stb_len = 0;
    int          bus_bad = 0;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr, exp_dat;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wbm_cyc !== wbm_stb) bus_bad++;
            if (wbm_stb) begin
                stb_len++;
                if (wbm_we !== exp_we || wbm_sel !== exp_sel ||
                    wbm_adr !== exp_adr || (exp_we && wbm_dat_o !== exp_dat))
                    bus_bad++;
            end
        end
    end

    // ---------------- reference model ----------------
    // A slave acking in stb cycle d is honoured if d < TIMEOUT; otherwise
    // the master gives up after TIMEOUT stb cycles with an error response.
    task automatic model(input logic we, input int delay, input logic [31:0] sdata,
                         output int len, output logic err, output logic [31:0] dat);
        if (delay < TO) begin
            len = delay + 1;
            err = 1'b0;
            dat = we ? 32'h0 : sdata;
        end else begin
            len = TO;
            err = 1'b1;
            dat = 32'hDEADBEEF;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int delay, input logic [31:0] sdata);
        int n;
        @(negedge clk);
        exp_we = we; exp_sel = sel; exp_adr = adr; exp_dat = dat;
        ack_delay = delay; slave_data = sdata;
        cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        cmd_valid = 1'b1;
        stb_len = 0; bus_bad = 0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL issue_wait: got cmd_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        // Garbage on the command bus once accepted must not matter.
        cmd_we = 1'($urandom); cmd_sel = 4'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic complete(input int exp_len, input logic exp_err, input logic [31:0] exp_rdat,
                            input int rsp_wait);
        int n;
        logic [31:0] d0;
        logic        e0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_wait: got rsp_valid=0 expected 1 within 100 cycles");
        end
        check("stb_len", 32'(stb_len), 32'(exp_len));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_dat", rsp_dat, exp_rdat);
        check("bus_fields_bad", 32'(bus_bad), 32'd0);
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        d0 = rsp_dat; e0 = rsp_err;
        stray_en = 1'b1;
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            check("rsp_hold_dat", rsp_dat, d0);
            check("rsp_hold_err", 32'(rsp_err), 32'(e0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        $display("txn %0d: we=%0b adr=%h stb_len=%0d err=%0b dat=%h", txn_no, exp_we, exp_adr,
                 stb_len, rsp_err, rsp_dat);
        txn_no++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          delay;
        logic [31:0] sdata;
        int          rsp_wait;
        int          exp_len;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] d0;
        int          n;
        int          seen;

        vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678, 2,     32'hFFFF_FFFF, 0,  3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         0,     32'hA5A5_0001, 1,  1, 1'b0, 32'hA5A5_0001};
        vecs[2] = '{1'b0, 4'h3, 32'h3000_0010, 32'h0,         NEVER, 32'h1111_2222, 2,  8, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 4'h1, 32'h3000_0020, 32'h0,         7,     32'h0BAD_F00D, 0,  8, 1'b0, 32'h0BAD_F00D};
        vecs[4] = '{1'b1, 4'hC, 32'h3000_0024, 32'hCAFE_0000, 7,     32'h5555_5555, 0,  8, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 4'h8, 32'h3000_0028, 32'h0000_00AA, 8,     32'h7777_7777, 1,  8, 1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 4'hF, 32'h3000_0030, 32'h0,         6,     32'h1122_3344, 10, 7, 1'b0, 32'h1122_3344};

        // Reset values, sampled while reset is held
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat",   rsp_dat,        32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_cyc_stb",   {30'd0, wbm_cyc, wbm_stb}, 32'd0);
        check("rst_we_sel",    {27'd0, wbm_we, wbm_sel}, 32'd0);
        check("rst_adr",       wbm_adr,        32'd0);
        check("rst_dat",       wbm_dat_o,      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stray acks in IDLE must not start anything
        stray_en = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_stray_busy", 32'(busy), 32'd0);
        check("idle_stray_rsp",  32'(rsp_valid), 32'd0);

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].delay, vecs[i].sdata);
            complete(vecs[i].exp_len, vecs[i].exp_err, vecs[i].exp_dat, vecs[i].rsp_wait);
        end

        // Back-pressure: a second command is refused until the response is taken
        issue(1'b0, 4'hF, 32'h3000_0040, 32'h0, 1, 32'h0ABC_DEF0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_dat", rsp_dat, 32'h0ABC_DEF0);
        d0 = rsp_dat;
        exp_we = 1'b1; exp_sel = 4'h5; exp_adr = 32'h3000_0044; exp_dat = 32'h0000_BEEF;
        cmd_we = 1'b1; cmd_sel = 4'h5; cmd_adr = 32'h3000_0044; cmd_dat = 32'h0000_BEEF;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_hold_dat", rsp_dat, d0);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_no_cyc", 32'(wbm_cyc), 32'd0);
        end
        ack_delay = 0; slave_data = 32'h0;
        stb_len = 0; bus_bad = 0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_after_hs", 32'(busy), 32'd0);
        check("bp_cyc_after_hs", 32'(wbm_cyc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_second_accepted", 32'(wbm_cyc), 32'd1);
        complete(1, 1'b0, 32'h0, 0);

        // Reset two cycles into BUS
        issue(1'b1, 4'hF, 32'h3000_0050, 32'h1357_9BDF, NEVER, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(wbm_cyc), 32'd0);
        check("mid_rst_stb", 32'(wbm_stb), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_adr", wbm_adr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        issue(1'b0, 4'h2, 32'h3000_0054, 32'h0, 3, 32'h2468_ACE0);
        complete(4, 1'b0, 32'h2468_ACE0, 1);

        // Randomized transactions against the rule model
        for (int i = 0; i < 40; i++) begin
            logic        r_we;
            int          r_delay;
            logic [31:0] r_sdata;
            int          m_len;
            logic        m_err;
            logic [31:0] m_dat;
            r_we    = 1'($urandom);
            r_delay = $urandom_range(0, 10);
            r_sdata = $urandom;
            stray_en = 1'($urandom);
            model(r_we, r_delay, r_sdata, m_len, m_err, m_dat);
            issue(r_we, 4'($urandom), $urandom, $urandom, r_delay, r_sdata);
            complete(m_len, m_err, m_dat, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_cmd_master
